spi_cmd_rx: RTL and testbench

- SPI-slave command receiver directly upstream of the waveform generator.
- Samples asynchronous sclk/cs_n/mosi in the system clk domain and deserialises an 18-bit MSB-first frame {divider[15:0], wform[1:0]}.
- Validates frame length and presents a registered divider/waveform pair with a one-cycle commit strobe consumed by the generator.

---
 rtl/spi_cmd_rx.sv | 187 ++++++++++++++++++
 tb/tb_spi_cmd_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_rx.sv
// spi_cmd_rx: SPI-slave command receiver feeding the waveform generator.
// Brings sclk/cs_n/mosi into the clk domain and shifts in an MSB-first frame
// {divider, wform}. A frame is committed only if it is exactly FRAME_LEN bits
// long, has a non-zero divider and a non-reserved waveform select.
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sclk, cs_n, mosi    asynchronous SPI pins (mode 0, rising-edge sample)
//   divider, wform      last committed command (registered)
//   cmd_valid           one-cycle pulse when divider/wform update
//   frame_err           one-cycle pulse when a frame is discarded
//   busy                high while a frame is being shifted in
module spi_cmd_rx #(
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned WF_W        = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEFAULT_DIV = 1000,
  parameter int unsigned DEFAULT_WF  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic [DIV_W-1:0] divider,
  output logic [WF_W-1:0]  wform,
  output logic             cmd_valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int unsigned FRAME_LEN = DIV_W + WF_W;
  localparam int unsigned CNT_W     = 5;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_SHIFT
  } state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_d;
  logic                   r_cs_d;
  logic [SYNC_STAGES:0]   r_prime;

  state_t                 r_state;
  logic [FRAME_LEN-1:0]   r_shift;
  logic [CNT_W-1:0]       r_cnt;
  logic [DIV_W-1:0]       r_divider;
  logic [WF_W-1:0]        r_wform;
  logic                   r_cmd_valid;
  logic                   r_frame_err;
  logic                   r_busy;

  logic                   w_sclk_s;
  logic                   w_cs_s;
  logic                   w_mosi_s;
  logic                   w_sclk_rise;
  logic                   w_cs_fall;
  logic                   w_cs_rise;
  logic                   w_primed;
  logic [FRAME_LEN-1:0]   w_shift_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_accept;

  // Input synchronizers, preset to the idle bus level, plus one edge-detect copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  // The synchronizer presets read as "cs_n high" right after reset; WAIT_IDLE
  // must not trust cs_n until the real pin level has propagated through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime <= '0;
    end else begin
      r_prime <= {r_prime[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_cs_fall   = ~w_cs_s & r_cs_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;
  assign w_primed    = r_prime[SYNC_STAGES];

  // Shift/count as they will be after this cycle's sclk edge, so a final bit
  // arriving with cs_rise is included in the length and field checks.
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    if (w_sclk_rise) begin
      w_shift_nxt = {r_shift[FRAME_LEN-2:0], w_mosi_s};
      if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  assign w_accept = (w_cnt_nxt == CNT_FRAME)
                  & (|w_shift_nxt[FRAME_LEN-1:WF_W])
                  & (w_shift_nxt[WF_W-1:0] != '1);

  // Frame state machine with registered command outputs and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_divider   <= DIV_W'(DEFAULT_DIV);
      r_wform     <= WF_W'(DEFAULT_WF);
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_WAIT_IDLE: begin
          r_busy <= 1'b0;
          if (w_primed && w_cs_s) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          r_busy <= 1'b0;
          if (w_cs_fall) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_cs_fall) begin
            // Glitched select: start over silently.
            r_cnt   <= '0;
            r_shift <= '0;
          end else if (w_cs_rise) begin
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
            if (w_accept) begin
              r_divider   <= w_shift_nxt[FRAME_LEN-1:WF_W];
              r_wform     <= w_shift_nxt[WF_W-1:0];
              r_cmd_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_WAIT_IDLE;
        end
      endcase
    end
  end

  assign divider   = r_divider;
  assign wform     = r_wform;
  assign cmd_valid = r_cmd_valid;
  assign frame_err = r_frame_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// tb_spi_cmd_rx: scoreboard bench for spi_cmd_rx. The stimulus side predicts
// the outcome of every frame (commit or discard) from the frame rules and
// pushes it into a queue; a monitor pops an entry for every strobe the DUT
// emits and compares it.
module tb_spi_cmd_rx;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned WF_W  = 2;

  typedef struct {
    bit                err;
    logic [DIV_W-1:0]  div;
    logic [WF_W-1:0]   wf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             sclk;
  logic             cs_n;
  logic             mosi;
  logic [DIV_W-1:0] divider;
  logic [WF_W-1:0]  wform;
  logic             cmd_valid;
  logic             frame_err;
  logic             busy;

  exp_t             exp_q[$];
  int               n_cmp;
  int               n_fail;
  logic [DIV_W-1:0] m_div;
  logic [WF_W-1:0]  m_wf;

  spi_cmd_rx #(
    .DIV_W(16), .WF_W(2), .SYNC_STAGES(2), .DEFAULT_DIV(1000), .DEFAULT_WF(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .divider(divider), .wform(wform), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Shift nbits of data out MSB first with half-period h; optionally release
  // cs_n together with the final rising sclk edge.
  task automatic send_bits(input logic [31:0] data, input int nbits, input int h,
                           input bit cs_on_last);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = data[i];
      clks(h);
      sclk = 1'b1;
      if (i == 0 && cs_on_last) cs_n = 1'b1;
      clks(h);
      sclk = 1'b0;
    end
  endtask

  // Predict the frame outcome, then drive the complete frame.
  task automatic send_frame(input logic [31:0] data, input int nbits, input int h,
                            input bit cs_on_last, input int gap);
    exp_t e;
    logic [DIV_W-1:0] fd;
    logic [WF_W-1:0]  fw;
    fd = data[17:2];
    fw = data[1:0];
    if (nbits == DIV_W + WF_W && fd != 0 && fw != 2'd3) begin
      m_div = fd;
      m_wf  = fw;
      e.err = 1'b0;
    end else begin
      e.err = 1'b1;
    end
    e.div = m_div;
    e.wf  = m_wf;
    exp_q.push_back(e);
    cs_n = 1'b0;
    send_bits(data, nbits, h, cs_on_last);
    if (!cs_on_last) begin
      clks(h);
      cs_n = 1'b1;
    end
    clks(gap);
  endtask

  // Monitor: every strobe must match the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (cmd_valid || frame_err)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got cmd_valid=%0b frame_err=%0b, expected none",
                   cmd_valid, frame_err);
        end else begin
          e = exp_q.pop_front();
          if (cmd_valid !== !e.err || frame_err !== e.err ||
              divider !== e.div || wform !== e.wf) begin
            n_fail++;
            $display("FAIL strobe: got cv=%0b fe=%0b div=%0d wf=%0d, expected cv=%0b fe=%0b div=%0d wf=%0d",
                     cmd_valid, frame_err, divider, wform, !e.err, e.err, e.div, e.wf);
          end
        end
      end
    end
  end

  initial begin
    int n;
    int h;
    logic [31:0] d;
    n_cmp  = 0;
    n_fail = 0;
    m_div  = 16'd1000;
    m_wf   = 2'd0;
    rst_n  = 1'b0;
    sclk   = 1'b0;
    cs_n   = 1'b1;
    mosi   = 1'b0;
    clks(3);
    rst_n = 1'b1;
    clks(10);
    check("reset_divider", 32'(divider), 32'd1000);
    check("reset_wform", 32'(wform), 32'd0);
    check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    // Single good frame, cs_n released with the last sclk edge.
    send_frame(32'({16'd500, 2'b10}), 18, 3, 1'b1, 10);
    check("f1_divider", 32'(divider), 32'd500);
    check("f1_wform", 32'(wform), 32'd2);

    // Back-to-back commits.
    send_frame(32'({16'd1000, 2'b00}), 18, 2, 1'b0, 5);
    send_frame(32'({16'd250, 2'b01}), 18, 3, 1'b1, 10);
    check("b2b_divider", 32'(divider), 32'd250);
    check("b2b_wform", 32'(wform), 32'd1);

    // Short and long frames.
    send_frame(32'h0001_5A5A, 17, 2, 1'b1, 10);
    send_frame(32'h0007_A5A5, 19, 3, 1'b0, 10);
    // Zero divider and reserved waveform.
    send_frame(32'({16'd0, 2'b01}), 18, 2, 1'b1, 10);
    send_frame(32'({16'd1234, 2'b11}), 18, 2, 1'b0, 10);
    check("held_divider", 32'(divider), 32'd250);
    check("held_wform", 32'(wform), 32'd1);

    // Reset in the middle of a frame while cs_n stays low.
    d = 32'({16'd777, 2'b10});
    cs_n = 1'b0;
    send_bits(d >> 9, 9, 3, 1'b0);
    check("busy_mid_frame", 32'(busy), 32'd1);
    rst_n = 1'b0;
    clks(2);
    check("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    m_div = 16'd1000;
    m_wf  = 2'd0;
    clks(2);
    send_bits(d, 9, 3, 1'b0);
    clks(3);
    cs_n = 1'b1;
    clks(12);
    check("midrst_divider", 32'(divider), 32'd1000);
    check("midrst_busy_after", 32'(busy), 32'd0);
    send_frame(32'({16'd300, 2'b01}), 18, 3, 1'b1, 10);
    check("post_rst_divider", 32'(divider), 32'd300);
    check("post_rst_wform", 32'(wform), 32'd1);

    // Randomized frames of every category.
    for (int k = 0; k < 40; k++) begin
      h = int'($urandom_range(2, 4));
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          d = 32'({16'($urandom_range(1, 65535)), 2'($urandom_range(0, 2))});
          n = 18;
        end
        3: begin
          n = int'($urandom_range(1, 23));
          if (n >= 18) n++;
          d = $urandom;
        end
        4: begin
          d = 32'({16'd0, 2'($urandom_range(0, 3))});
          n = 18;
        end
        default: begin
          d = 32'({16'($urandom), 2'b11});
          n = 18;
        end
      endcase
      send_frame(d, n, h, 1'($urandom_range(0, 1)), int'($urandom_range(5, 9)));
    end

    // Drain outstanding predictions with a bounded wait.
    for (int t = 0; t < 300 && exp_q.size() != 0; t++) clks(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_divider", 32'(divider), 32'(m_div));
    check("final_wform", 32'(wform), 32'(m_wf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
